// File: rtl/iceb_pmod_keypad.sv
// iceb_pmod_keypad: column scanner and decoder for a 4x4 hex keypad PMOD.
//
// One column is driven low at a time. The active-low rows are synchronized,
// and one 4-bit sample is captured at the end of each column slot. After the
// fourth column, the complete 16-bit snapshot is debounced against the
// previous snapshot. A debounced map with exactly one key, when it changes,
// becomes a key event. The event's hex digit is shifted into value_o.
//
// Map bit layout: bit index = column*4 + row (row 0 = top, column 0 = left).
module iceb_pmod_keypad #(
  parameter int SCAN_CYCLES    = 256,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col_o,
  input  logic [3:0] row_i,
  input  logic       value_clear_i,
  output logic [3:0] key_o,
  output logic       key_valid_o,
  output logic       key_down_o,
  output logic [7:0] value_o
);

  localparam int CW = $clog2(SCAN_CYCLES);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  logic [CW-1:0] cnt;
  logic [1:0]    col_idx;
  logic [3:0]    row_s1, row_s2;
  logic [15:0]   raw, prev, deb, deb_old;
  logic          deb_upd;
  logic [SW-1:0] stable;

  logic [3:0]    r;
  logic          sample;
  logic [15:0]   new_raw;
  logic [SW-1:0] stable_next;
  logic          one_hot;
  logic [3:0]    key_idx;
  logic          event_now;

  // Decode a map bit index (column*4 + row) into the hex legend on the keypad.
  function automatic logic [3:0] key_code(input logic [3:0] idx);
    logic [3:0] k;
    case (idx)
      4'd0:    k = 4'h1;
      4'd1:    k = 4'h4;
      4'd2:    k = 4'h7;
      4'd3:    k = 4'h0;
      4'd4:    k = 4'h2;
      4'd5:    k = 4'h5;
      4'd6:    k = 4'h8;
      4'd7:    k = 4'hF;
      4'd8:    k = 4'h3;
      4'd9:    k = 4'h6;
      4'd10:   k = 4'h9;
      4'd11:   k = 4'hE;
      4'd12:   k = 4'hA;
      4'd13:   k = 4'hB;
      4'd14:   k = 4'hC;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Derive the sample strobe, the complete snapshot, and the next stable count.
  always_comb begin
    r       = ~row_s2;
    sample  = (cnt == CNT_LAST);
    // Valid only in the column-3 sample cycle; the column-3 rows come straight from r.
    new_raw = {r, raw[11:0]};
    if (new_raw == prev) begin
      stable_next = (stable == STABLE_MAX) ? STABLE_MAX : stable + 1'b1;
    end else begin
      stable_next = SW'(1);
    end
  end

  // Check the debounced map for a single pressed key, and locate it.
  always_comb begin
    one_hot = (deb != 16'd0) && ((deb & (deb - 16'd1)) == 16'd0);
    key_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (deb[i]) key_idx = 4'(i);
    end
    event_now = deb_upd && one_hot && (deb != deb_old);
  end

  // Scan the columns, capture the rows, and debounce each complete snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      col_idx <= 2'd0;
      col_o   <= 4'b1110;
      row_s1  <= 4'hF;
      row_s2  <= 4'hF;
      raw     <= 16'd0;
      prev    <= 16'd0;
      deb     <= 16'd0;
      deb_old <= 16'd0;
      deb_upd <= 1'b0;
      stable  <= '0;
    end else begin
      row_s1  <= row_i;
      row_s2  <= row_s1;
      deb_upd <= 1'b0;
      if (sample) begin
        cnt     <= '0;
        col_idx <= col_idx + 2'd1;
        col_o   <= {col_o[2:0], col_o[3]};
        raw[{col_idx, 2'b00} +: 4] <= r;
        if (col_idx == 2'd3) begin
          prev   <= new_raw;
          stable <= stable_next;
          if (stable_next == STABLE_MAX) begin
            deb     <= new_raw;
            deb_old <= deb;
            deb_upd <= 1'b1;
          end
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Turn each debounced update into a key event, and maintain the entered byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_o       <= 4'h0;
      key_valid_o <= 1'b0;
      key_down_o  <= 1'b0;
      value_o     <= 8'h00;
    end else begin
      key_valid_o <= event_now;
      key_down_o  <= |deb;
      if (event_now) begin
        key_o   <= key_code(key_idx);
        // A clear that coincides with an event still keeps the new digit.
        value_o <= {(value_clear_i ? 4'h0 : value_o[3:0]), key_code(key_idx)};
      end else if (value_clear_i) begin
        value_o <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_iceb_pmod_keypad.sv
// tb_iceb_pmod_keypad: directed bench with a scoreboard for the keypad scanner.
// The keypad model pulls a row low whenever a pressed key's column is driven low.
module tb_iceb_pmod_keypad;

  logic       clk;
  logic       reset;
  logic [3:0] col_o;
  logic [3:0] row_i;
  logic       value_clear_i;
  logic [3:0] key_o;
  logic       key_valid_o;
  logic       key_down_o;
  logic [7:0] value_o;

  // Pressed keys; bit index = column*4 + row.
  logic [15:0] keys;

  // Each entry is {expected key_o, expected value_o}.
  logic [11:0] exp_q[$];
  int tests;
  int fails;
  int pulse_cnt;

  iceb_pmod_keypad #(
    .SCAN_CYCLES   (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .col_o        (col_o),
    .row_i        (row_i),
    .value_clear_i(value_clear_i),
    .key_o        (key_o),
    .key_valid_o  (key_valid_o),
    .key_down_o   (key_down_o),
    .value_o      (value_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- keypad model ----------------
  always_comb begin
    row_i = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        if (keys[c*4+rr] && !col_o[c]) row_i[rr] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [11:0] e;
    if (!reset && key_valid_o) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: key_o=%h value_o=%h, expected no pulse", key_o, value_o);
      end else begin
        e = exp_q.pop_front();
        check("event_key", {12'd0, key_o}, {12'd0, e[11:8]});
        check("event_value", {8'd0, value_o}, {8'd0, e[7:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_scans(input int n);
    repeat (n * 16) @(negedge clk);
  endtask

  // Return at the negedge where column 0 has just become active.
  task automatic align_scan();
    logic [3:0] p;
    logic found;
    found = 1'b0;
    p = col_o;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (col_o == 4'b1110 && p == 4'b0111) begin
        found = 1'b1;
        break;
      end
      p = col_o;
    end
    check("align_found", {15'd0, found}, 16'd1);
  endtask

  task automatic press_release(input int idx, input logic [3:0] k, input logic [7:0] v);
    keys = 16'd0;
    keys[idx] = 1'b1;
    exp_q.push_back({k, v});
    wait_scans(4);
    keys = 16'd0;
    wait_scans(4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, {12'd0, col_o}, 16'h000E);
    check({tag, "_valid"}, {15'd0, key_valid_o}, 16'd0);
    check({tag, "_key"}, {12'd0, key_o}, 16'd0);
    check({tag, "_down"}, {15'd0, key_down_o}, 16'd0);
    check({tag, "_value"}, {8'd0, value_o}, 16'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] col_seq [4];
    int p0;
    int n;
    col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    tests = 0;
    fails = 0;
    pulse_cnt = 0;
    keys = 16'd0;
    value_clear_i = 1'b0;
    reset = 1'b1;

    // 1: reset values and the column walk.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    for (int k = 0; k < 32; k++) begin
      check("col_walk", {12'd0, col_o}, {12'd0, col_seq[(k / 4) % 4]});
      @(negedge clk);
    end

    // 2: single key "6" (row 1, column 2); one pulse; no repeat while held.
    wait_scans(2);
    keys = 16'd0;
    keys[9] = 1'b1;
    exp_q.push_back({4'h6, 8'h06});
    p0 = pulse_cnt;
    wait_scans(4);
    check("six_down", {15'd0, key_down_o}, 16'd1);
    check("six_key", {12'd0, key_o}, 16'h0006);
    check("six_value", {8'd0, value_o}, 16'h0006);
    wait_scans(10);
    check("six_one_pulse", 16'(pulse_cnt - p0), 16'd1);
    keys = 16'd0;
    wait_scans(4);
    check("six_release_down", {15'd0, key_down_o}, 16'd0);

    // 3: A, then 5, then 0 shift through value_o.
    press_release(12, 4'hA, 8'h6A);
    press_release(5, 4'h5, 8'hA5);
    check("value_a5", {8'd0, value_o}, 16'h00A5);
    press_release(3, 4'h0, 8'h50);
    check("value_50", {8'd0, value_o}, 16'h0050);

    // 4: key "3" bounces on alternate scans, then is held.
    align_scan();
    p0 = pulse_cnt;
    for (int i = 0; i < 6; i++) begin
      keys = 16'd0;
      if (i % 2 == 0) keys[8] = 1'b1;
      wait_scans(1);
    end
    check("bounce_no_pulse", 16'(pulse_cnt - p0), 16'd0);
    keys = 16'd0;
    keys[8] = 1'b1;
    exp_q.push_back({4'h3, 8'h03});
    wait_scans(4);
    check("bounce_one_pulse", 16'(pulse_cnt - p0), 16'd1);
    check("bounce_key", {12'd0, key_o}, 16'h0003);
    keys = 16'd0;
    wait_scans(4);

    // 5: "1" and "9" together give no event; releasing "1" leaves "9".
    p0 = pulse_cnt;
    keys = 16'd0;
    keys[0] = 1'b1;
    keys[10] = 1'b1;
    wait_scans(4);
    check("two_keys_down", {15'd0, key_down_o}, 16'd1);
    check("two_keys_no_pulse", 16'(pulse_cnt - p0), 16'd0);
    keys[0] = 1'b0;
    exp_q.push_back({4'h9, 8'h39});
    wait_scans(4);
    check("nine_key", {12'd0, key_o}, 16'h0009);
    keys = 16'd0;
    wait_scans(4);

    // 6a: clear coinciding with the "D" event. "D" is sampled at the end of the
    // first scan (posedge 16), and it is confirmed at posedge 32. The event
    // registers at posedge 33, which is counted from the aligned column-0 negedge.
    align_scan();
    keys = 16'd0;
    keys[15] = 1'b1;
    exp_q.push_back({4'hD, 8'h0D});
    repeat (32) @(posedge clk);
    @(negedge clk);
    value_clear_i = 1'b1;
    @(negedge clk);
    value_clear_i = 1'b0;
    check("d_latency_valid", {15'd0, key_valid_o}, 16'd1);
    check("d_clear_value", {8'd0, value_o}, 16'h000D);

    // The clear alone zeroes value_o but leaves key_o alone.
    @(negedge clk);
    value_clear_i = 1'b1;
    @(negedge clk);
    value_clear_i = 1'b0;
    check("clear_alone_value", {8'd0, value_o}, 16'h0000);
    check("clear_alone_key", {12'd0, key_o}, 16'h000D);

    // 6b: reset mid-scan while "D" is held; a fresh event follows 33 edges later.
    repeat (7) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset");
    exp_q.push_back({4'hD, 8'h0D});
    reset = 1'b0;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (key_valid_o) break;
    end
    check("reset_d_latency", 16'(n), 16'd33);
    wait_scans(2);
    keys = 16'd0;
    wait_scans(4);
    check("release_final_down", {15'd0, key_down_o}, 16'd0);

    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
